// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
// Shared types for the multi-core memory arbiter.
//   word_t      : one RAM word
//   ramstate_t  : RAM handshake state (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t : arbiter FSM states
//   rr_advance  : round-robin pointer step after a grant
package memory_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } arb_state_t;

  // The requester after the winner gets first look next time.
  function automatic int rr_advance(input int winner, input int n);
    return (winner + 1) % n;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
// Bundles the per-core cache request/response signals and the single RAM port.
//   Cache side : iREN/iaddr -> iwait/iload, dREN/dWEN/daddr/dstore -> dwait/dload
//   RAM side   : ramREN/ramWEN/ramaddr/ramstore -> ramload/ramstate
// Modports:
//   slave  : the arbiter (consumes requests, drives waits and RAM strobes)
//   master : the caches plus RAM model surrounding it
interface memory_arbiter_if
  import memory_arbiter_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int WORD_W = 32
) ();

  logic [NCORES-1:0]             iREN;
  logic [NCORES-1:0][WORD_W-1:0] iaddr;
  logic [NCORES-1:0]             iwait;
  logic [WORD_W-1:0]             iload;

  logic [NCORES-1:0]             dREN;
  logic [NCORES-1:0]             dWEN;
  logic [NCORES-1:0][WORD_W-1:0] daddr;
  logic [NCORES-1:0][WORD_W-1:0] dstore;
  logic [NCORES-1:0]             dwait;
  logic [WORD_W-1:0]             dload;

  logic                          ramREN;
  logic                          ramWEN;
  logic [WORD_W-1:0]             ramaddr;
  logic [WORD_W-1:0]             ramstore;
  logic [WORD_W-1:0]             ramload;
  ramstate_t                     ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin selector over N request lines.
//   req   in  N   request vector
//   ptr   in  IW  index where the search starts
//   valid out 1   some request is high
//   idx   out IW  first requesting index at or after ptr (wrapping)
module rr_picker #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int cand;

  // Walk the offsets from farthest to nearest so the nearest hit is the
  // last assignment and therefore the winner.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N;
      if (req[IW'(cand)]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one RAM port among NCORES cores (one icache + one dcache each).
// Dcaches outrank icaches, round robin inside each class; a dcache keeps the
// port for a whole block until it drops its request, and one icache word is
// owed after every dcache tenure so instruction fetch cannot starve.
//   CLK   in  clock
//   nRST  in  asynchronous active-low reset
//   bus   slave modport of memory_arbiter_if (cache requests, RAM port)
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int WORD_W = 32
) (
  input logic             CLK,
  input logic             nRST,
  memory_arbiter_if.slave bus
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  arb_state_t        state, state_next;
  logic [IW-1:0]     owner, owner_next;
  logic [IW-1:0]     d_rr, d_rr_next;
  logic [IW-1:0]     i_rr, i_rr_next;
  logic              i_owed, i_owed_next;

  logic [NCORES-1:0] d_req;
  logic              d_valid, i_valid;
  logic [IW-1:0]     d_idx, i_idx;
  logic              ram_ready;

  logic [NCORES-1:0] d_wait, i_wait;
  logic              ram_ren, ram_wen;
  logic [WORD_W-1:0] ram_addr, ram_store;

  assign d_req     = bus.dREN | bus.dWEN;
  assign ram_ready = (bus.ramstate == ACCESS);

  rr_picker #(.N(NCORES)) d_pick (
    .req   (d_req),
    .ptr   (d_rr),
    .valid (d_valid),
    .idx   (d_idx)
  );

  rr_picker #(.N(NCORES)) i_pick (
    .req   (bus.iREN),
    .ptr   (i_rr),
    .valid (i_valid),
    .idx   (i_idx)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      owner  <= '0;
      d_rr   <= '0;
      i_rr   <= '0;
      i_owed <= 1'b0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      d_rr   <= d_rr_next;
      i_rr   <= i_rr_next;
      i_owed <= i_owed_next;
    end
  end

  // An owed icache word beats any dcache; otherwise dcaches go first.
  // ERROR and FREE look like BUSY here: the grant simply stays put.
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    d_rr_next   = d_rr;
    i_rr_next   = i_rr;
    i_owed_next = i_owed;
    case (state)
      IDLE: begin
        if (i_owed && i_valid) begin
          state_next = GRANT_I;
          owner_next = i_idx;
          i_rr_next  = IW'(rr_advance(int'(i_idx), NCORES));
        end else if (d_valid) begin
          state_next = GRANT_D;
          owner_next = d_idx;
          d_rr_next  = IW'(rr_advance(int'(d_idx), NCORES));
        end else if (i_valid) begin
          state_next = GRANT_I;
          owner_next = i_idx;
          i_rr_next  = IW'(rr_advance(int'(i_idx), NCORES));
        end
      end
      GRANT_D: begin
        if (!d_req[owner]) begin
          state_next = IDLE;
          if (|bus.iREN) begin
            i_owed_next = 1'b1;
          end
        end
      end
      GRANT_I: begin
        if (ram_ready) begin
          state_next  = IDLE;
          i_owed_next = 1'b0;
        end else if (!bus.iREN[owner]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM port steering; a dcache asserting both strobes is treated as a write.
  always_comb begin
    d_wait    = '1;
    i_wait    = '1;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    case (state)
      GRANT_D: begin
        ram_addr      = bus.daddr[owner];
        ram_store     = bus.dstore[owner];
        ram_wen       = bus.dWEN[owner];
        ram_ren       = bus.dREN[owner] & ~bus.dWEN[owner];
        d_wait[owner] = ~ram_ready;
      end
      GRANT_I: begin
        ram_ren       = 1'b1;
        ram_addr      = bus.iaddr[owner];
        i_wait[owner] = ~ram_ready;
      end
      default: ;
    endcase
  end

  assign bus.dwait    = d_wait;
  assign bus.iwait    = i_wait;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Self-checking bench for memory_arbiter: directed scenarios plus a random
// traffic phase, all outputs compared each cycle against a reference model.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int NC = 2;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  memory_arbiter_if #(.NCORES(NC), .WORD_W(32)) bus ();

  memory_arbiter #(.NCORES(NC), .WORD_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: who holds the port (0 none, 1 dcache, 2 icache)
  int      m_kind, m_owner, m_dptr, m_iptr;
  bit      m_owed;
  logic [NC-1:0] m_dcomp, m_icomp;

  logic [NC-1:0] obs_dwait, obs_iwait;
  logic          obs_ren, obs_wen;
  logic [31:0]   obs_addr, obs_dload;
  logic [31:0]   ram_data;

  // completion log: D0=0, D1=1, I0=2, I1=3
  int events[$];

  bit            rand_mode;
  logic [NC-1:0] want_d, want_i;
  int            low_cnt;

  logic [31:0] b2b_addr [8] = '{32'h200, 32'h200, 32'h204, 32'h300, 32'h304, 32'h0, 32'h0, 32'h0};
  logic        b2b_wen  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        b2b_ren  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int pickRr(input logic [NC-1:0] req, input int ptr);
    for (int k = 0; k < NC; k++) begin
      if (req[(ptr + k) % NC]) return (ptr + k) % NC;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_kind  = 0;
    m_owner = 0;
    m_dptr  = 0;
    m_iptr  = 0;
    m_owed  = 1'b0;
  endtask

  task automatic clearInputs();
    bus.iREN     = '0;
    bus.iaddr    = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramstate = FREE;
    ram_data     = '0;
    bus.ramload  = ram_data;
  endtask

  // Runs one clock cycle with whatever inputs are currently driven:
  // checks outputs mid-cycle, then advances the model over the edge.
  task automatic applyStimulus();
    logic [NC-1:0] exp_iwait, exp_dwait, dreq;
    logic          exp_ren, exp_wen, acc;
    logic [31:0]   exp_addr, exp_store;
    int            ip, dp;
    @(negedge CLK);
    if (!nRST) modelReset();
    acc       = (bus.ramstate == ACCESS);
    dreq      = bus.dREN | bus.dWEN;
    exp_iwait = '1;
    exp_dwait = '1;
    exp_ren   = 1'b0;
    exp_wen   = 1'b0;
    exp_addr  = '0;
    exp_store = '0;
    if (m_kind == 1) begin
      exp_addr           = bus.daddr[m_owner];
      exp_store          = bus.dstore[m_owner];
      exp_wen            = bus.dWEN[m_owner];
      exp_ren            = bus.dREN[m_owner] && !bus.dWEN[m_owner];
      exp_dwait[m_owner] = !acc;
    end else if (m_kind == 2) begin
      exp_addr           = bus.iaddr[m_owner];
      exp_ren            = 1'b1;
      exp_iwait[m_owner] = !acc;
    end
    obs_dwait = bus.dwait;
    obs_iwait = bus.iwait;
    obs_ren   = bus.ramREN;
    obs_wen   = bus.ramWEN;
    obs_addr  = bus.ramaddr;
    obs_dload = bus.dload;
    checkOutput("iwait", 64'(obs_iwait), 64'(exp_iwait));
    checkOutput("dwait", 64'(obs_dwait), 64'(exp_dwait));
    checkOutput("ramREN", 64'(obs_ren), 64'(exp_ren));
    checkOutput("ramWEN", 64'(obs_wen), 64'(exp_wen));
    checkOutput("ramaddr", 64'(obs_addr), 64'(exp_addr));
    checkOutput("ramstore", 64'(bus.ramstore), 64'(exp_store));
    if (exp_dwait != '1) checkOutput("dload", 64'(obs_dload), 64'(ram_data));
    if (exp_iwait != '1) checkOutput("iload", 64'(bus.iload), 64'(ram_data));
    m_dcomp = ~exp_dwait;
    m_icomp = ~exp_iwait;
    for (int c = 0; c < NC; c++) begin
      if (obs_dwait[c] === 1'b0) events.push_back(c);
      if (obs_iwait[c] === 1'b0) events.push_back(2 + c);
    end
    if (nRST) begin
      case (m_kind)
        0: begin
          ip = pickRr(bus.iREN, m_iptr);
          dp = pickRr(dreq, m_dptr);
          if (m_owed && ip >= 0) begin
            m_kind = 2; m_owner = ip; m_iptr = (ip + 1) % NC;
          end else if (dp >= 0) begin
            m_kind = 1; m_owner = dp; m_dptr = (dp + 1) % NC;
          end else if (ip >= 0) begin
            m_kind = 2; m_owner = ip; m_iptr = (ip + 1) % NC;
          end
        end
        1: begin
          if (!dreq[m_owner]) begin
            m_kind = 0;
            if (|bus.iREN) m_owed = 1'b1;
          end
        end
        default: begin
          if (acc) begin
            m_kind = 0;
            m_owed = 1'b0;
          end else if (!bus.iREN[m_owner]) begin
            m_kind = 0;
          end
        end
      endcase
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    nRST       = 1'b0;
    bus.iREN   = '1;
    bus.dREN   = '1;
    bus.dWEN   = '1;
    bus.daddr  = {32'h0bad_0001, 32'h0bad_0000};
    bus.iaddr  = {32'h0bad_1001, 32'h0bad_1000};
    applyStimulus();
    checkOutput("rst_iwait", 64'(obs_iwait), 64'h3);
    checkOutput("rst_dwait", 64'(obs_dwait), 64'h3);
    checkOutput("rst_strobes", 64'({obs_ren, obs_wen}), 64'h0);
    applyStimulus();
    clearInputs();
    nRST    = 1'b1;
    m_dcomp = '0;
    m_icomp = '0;
    events.delete();
  endtask

  // Cache/RAM behaviour: random traffic, or simple caches that drop their
  // request for one cycle after each completed word.
  task automatic driveAgents();
    for (int c = 0; c < NC; c++) begin
      if (rand_mode) begin
        if (!((bus.dREN[c] || bus.dWEN[c]) && !m_dcomp[c] && $urandom_range(7) != 0)) begin
          bus.dREN[c]   = 1'($urandom_range(1));
          bus.dWEN[c]   = ($urandom_range(3) == 0);
          bus.daddr[c]  = $urandom;
          bus.dstore[c] = $urandom;
        end
        if (!(bus.iREN[c] && !m_icomp[c] && $urandom_range(7) != 0)) begin
          bus.iREN[c]  = 1'($urandom_range(1));
          bus.iaddr[c] = $urandom;
        end
      end else begin
        bus.dREN[c]   = want_d[c] & ~m_dcomp[c];
        bus.dWEN[c]   = 1'b0;
        bus.daddr[c]  = 32'h1000 + 32'(c * 16);
        bus.dstore[c] = 32'hd00 + 32'(c);
        bus.iREN[c]   = want_i[c];
        bus.iaddr[c]  = 32'h2000 + 32'(c * 4);
      end
    end
    if (rand_mode) bus.ramstate = ramstate_t'($urandom_range(3));
    else bus.ramstate = (|m_dcomp) ? FREE : ACCESS;
    ram_data    = $urandom;
    bus.ramload = ram_data;
  endtask

  task automatic runEvents(input int n, input int budget);
    events.delete();
    for (int k = 0; k < budget && events.size() < n; k++) begin
      driveAgents();
      applyStimulus();
    end
    checkOutput("evt_count", 64'(events.size()), 64'(n));
  endtask

  task automatic checkEvent(input string tag, input int i, input int code);
    checkOutput(tag, 64'((i < events.size()) ? events[i] : -1), 64'(code));
  endtask

  initial begin
    clearInputs();
    nRST = 1'b0;
    modelReset();
    m_dcomp   = '0;
    m_icomp   = '0;
    rand_mode = 1'b0;
    want_d    = '0;
    want_i    = '0;

    $display("[TB] reset, then single dcache read with two BUSY cycles");
    doReset();
    bus.dREN[0]  = 1'b1;
    bus.daddr[0] = 32'h100;
    bus.ramstate = BUSY;
    applyStimulus();
    checkOutput("bubble_ren", 64'(obs_ren), 64'h0);
    low_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      bus.ramstate = (k == 2) ? ACCESS : BUSY;
      ram_data     = $urandom;
      bus.ramload  = ram_data;
      applyStimulus();
      checkOutput("rd_ren", 64'(obs_ren), 64'h1);
      checkOutput("rd_addr", 64'(obs_addr), 64'h100);
      if (obs_dwait[0] === 1'b0) begin
        low_cnt++;
        checkOutput("rd_dload", 64'(obs_dload), 64'(ram_data));
      end
    end
    bus.dREN[0]  = 1'b0;
    bus.ramstate = FREE;
    applyStimulus();
    if (obs_dwait[0] === 1'b0) low_cnt++;
    checkOutput("rd_one_pulse", 64'(low_cnt), 64'h1);

    $display("[TB] back-to-back dcache block while core1 waits");
    doReset();
    bus.dREN[1]  = 1'b1;
    bus.daddr[1] = 32'h500;
    for (int k = 0; k < 8; k++) begin
      bus.dWEN[0]   = b2b_wen[k];
      bus.dREN[0]   = b2b_ren[k];
      bus.daddr[0]  = b2b_addr[k];
      bus.dstore[0] = 32'ha0 + 32'(k);
      bus.ramstate  = (k == 5) ? FREE : ACCESS;
      applyStimulus();
      if (k >= 1 && k <= 4) begin
        checkOutput("b2b_addr", 64'(obs_addr), 64'(b2b_addr[k]));
        checkOutput("b2b_wen", 64'(obs_wen), 64'(b2b_wen[k]));
        checkOutput("b2b_d0_done", 64'(obs_dwait[0]), 64'h0);
      end
      if (k <= 6) begin
        checkOutput("b2b_core1_held", 64'(obs_dwait[1]), 64'h1);
      end else begin
        checkOutput("b2b_core1_wins", 64'(obs_dwait), 64'h1);
        checkOutput("b2b_core1_addr", 64'(obs_addr), 64'h500);
      end
    end

    $display("[TB] owed icache word between dcache tenures");
    doReset();
    rand_mode = 1'b0;
    want_d    = 2'b11;
    want_i    = 2'b10;
    runEvents(4, 40);
    checkEvent("order_d0", 0, 0);
    checkEvent("order_i1a", 1, 3);
    checkEvent("order_d1", 2, 1);
    checkEvent("order_i1b", 3, 3);

    $display("[TB] dcache round robin starting from pointer 1");
    doReset();
    want_d = 2'b01;
    want_i = 2'b00;
    runEvents(1, 20);
    checkEvent("rr_setup", 0, 0);
    want_d = 2'b11;
    runEvents(2, 40);
    checkEvent("rr1_first", 0, 1);
    checkEvent("rr1_second", 1, 0);

    $display("[TB] dcache round robin starting from pointer 0");
    doReset();
    want_d = 2'b11;
    runEvents(2, 40);
    checkEvent("rr0_first", 0, 0);
    checkEvent("rr0_second", 1, 1);

    $display("[TB] async reset during a stalled write");
    doReset();
    bus.dWEN[0]  = 1'b1;
    bus.daddr[0] = 32'h400;
    bus.ramstate = BUSY;
    applyStimulus();
    applyStimulus();
    #2;
    checkOutput("ar_wen_before", 64'(bus.ramWEN), 64'h1);
    nRST = 1'b0;
    #1;
    checkOutput("ar_wen_drop", 64'(bus.ramWEN), 64'h0);
    applyStimulus();
    nRST = 1'b1;
    applyStimulus();
    checkOutput("ar_idle_strobes", 64'({obs_ren, obs_wen}), 64'h0);
    checkOutput("ar_idle_dwait", 64'(obs_dwait), 64'h3);

    $display("[TB] random traffic");
    doReset();
    rand_mode = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      driveAgents();
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
